pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
- Sits directly downstream of the system/SDRAM PLL wrapper. Consumes its `locked` output and drives its `rst` input.
- Generates a clean system reset for logic clocked by the PLL outputs. That reset is released only after lock has been continuously stable for a programmable time.
- Re-sequences the PLL automatically on lock loss or lock timeout. Also supports a software-requested re-sequence.
- Clocked from the free-running 50 MHz reference clock, never from a PLL output.

Parameters:
- PLL_RST_CYCLES, 16: cycles `pll_rst` is held high per reset attempt. Must be >= 1.
- LOCK_TIMEOUT, 65536: cycles to wait for lock before re-resetting the PLL. Must be >= 1.
- STABLE_CYCLES, 1024: cycles synchronized lock must stay high before `sys_rst` is released. Must be >= 1.

Ports:
- refclk  input  1  reference clock (50 MHz); all state on its rising edge.
- rst  input  1  synchronous, active-high reset.
- locked  input  1  PLL lock; asynchronous to refclk.
- sw_reset_req  input  1  single-cycle request to re-sequence PLL and system.
- pll_rst  output  1  reset to PLL; high in PLL_RESET state.
- sys_rst  output  1  system reset; low only in RUN state.
- ready  output  1  equals ~sys_rst.
- lock_timeout  output  1  one-cycle pulse when WAIT_LOCK times out.
- lock_loss_count  output  8  saturating count of lock losses in RUN (see Optional Feature).

Behaviour:
- Clock and reset: one clock, `refclk`. Reset `rst` is synchronous and active-high.
- Synchronizer: `locked` passes through a 2-flop synchronizer to produce `lock_s`. Both flops reset to 0.
- Counter: a single shared counter `cnt`, width `$clog2(max(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES))`, minimum 1 bit. It is cleared on every state change.
- Reset values (rst=1 at an edge):
  - state = PLL_RESET, cnt = 0
  - pll_rst = 1, sys_rst = 1, ready = 0
  - lock_timeout = 0, lock_loss_count = 0
- Outputs: `pll_rst`, `sys_rst` and `ready` are decoded from the registered state (Moore). `lock_timeout` is a registered pulse.
- PLL_RESET:
  - pll_rst = 1, sys_rst = 1.
  - cnt increments each cycle.
  - When cnt == PLL_RST_CYCLES-1 → WAIT_LOCK. `pll_rst` is therefore high for exactly PLL_RST_CYCLES cycles.
- WAIT_LOCK:
  - pll_rst = 0, sys_rst = 1.
  - If lock_s = 1 → STABLE.
  - Else if cnt == LOCK_TIMEOUT-1 → PLL_RESET, and `lock_timeout` = 1 for the next cycle.
  - Else cnt++.
- STABLE:
  - pll_rst = 0, sys_rst = 1.
  - If lock_s = 0 → WAIT_LOCK (glitch restarts the qualification).
  - Else if cnt == STABLE_CYCLES-1 → RUN.
  - Else cnt++.
- RUN:
  - pll_rst = 0, sys_rst = 0, ready = 1.
  - If lock_s = 0 → PLL_RESET, and `lock_loss_count` increments, saturating at 255.
  - Else if sw_reset_req = 1 → PLL_RESET; the count does not change.
  - If both occur in the same cycle, lock loss wins and the count increments once.
- sw_reset_req outside RUN is ignored; the sequence is already in progress.
- Latency: with `locked` held high, RUN is entered on the (STABLE_CYCLES+3)-th rising edge. Edge 1 is the first edge that samples locked = 1. The count is 2 synchronizer edges + 1 transition edge + STABLE_CYCLES.
- Lock loss in RUN: `sys_rst` rises on the 3rd edge after `locked` falls (2 sync + 1 transition).
- rst asserted mid-sequence (any state): the next edge forces the reset values. The sequence restarts from PLL_RESET.
- Parameter value 1: the state is left after exactly one cycle. No counter underflow or wrap is permitted.

Optional Feature:
- Macro: PLL_RSTSEQ_LOSS_CNT_EN.
- Defined: the 8-bit saturating lock-loss counter is implemented as described. It clears only on rst.
- Undefined: the counter register is not built. `lock_loss_count` is tied to 8'd0. All other behaviour is identical.

Test Plan:
All scenarios use PLL_RST_CYCLES=4, LOCK_TIMEOUT=16, STABLE_CYCLES=8 unless stated.
1. Power-up: rst high for 3 cycles, then low; locked = 0 throughout → pll_rst high for exactly 4 cycles after rst release; sys_rst = 1, ready = 0 throughout.
2. Normal lock: raise locked 2 cycles into WAIT_LOCK and hold → sys_rst falls and ready rises on the 11th edge after locked rises; pll_rst stays 0.
3. Timeout: locked held 0 → after 16 WAIT_LOCK cycles, lock_timeout pulses for 1 cycle and pll_rst goes high for 4 cycles. This repeats periodically with period 20 cycles.
4. Lock glitch: in STABLE at cnt = 5, drop locked for 1 cycle, then restore → return to WAIT_LOCK; sys_rst released only 11 edges after the restore.
5. Lock loss: in RUN, drop locked → sys_rst = 1 on the 3rd edge and pll_rst = 1. lock_loss_count 0→1 with the macro defined, 0 without. Repeat 300 times → count = 255.
6. Simultaneous: in RUN, assert sw_reset_req on the same cycle lock_s falls → single PLL_RESET entry, count +1. sw_reset_req alone → PLL_RESET, count unchanged. rst asserted in STABLE → reset values on the next edge.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// ----------------------------------------------------------------------------
// pll_reset_sequencer
//
// Purpose:
//   Sequences the system/SDRAM PLL out of reset and holds the system reset
//   until the PLL lock has been continuously stable for STABLE_CYCLES cycles.
//   The PLL is re-sequenced automatically in three cases:
//     - lock loss while running,
//     - lock timeout while waiting for lock,
//     - a software request.
//   All logic runs on the free-running reference clock, never on a PLL output.
//
// Optional feature:
//   Define PLL_RSTSEQ_LOSS_CNT_EN to build the 8-bit saturating lock-loss
//   counter. Without it, lock_loss_count is tied to zero.
//
// Ports:
//   refclk          in   reference clock; all state updates on its rising edge
//   rst             in   synchronous active-high reset
//   locked          in   PLL lock, asynchronous to refclk
//   sw_reset_req    in   single-cycle request to re-sequence (used only in RUN)
//   pll_rst         out  reset to the PLL, high in PLL_RESET
//   sys_rst         out  system reset, low only in RUN
//   ready           out  ~sys_rst
//   lock_timeout    out  one-cycle pulse after a WAIT_LOCK timeout
//   lock_loss_count out  saturating count of lock losses seen in RUN
// ----------------------------------------------------------------------------
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int STABLE_CYCLES  = 1024
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked,
    input  logic       sw_reset_req,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       lock_timeout,
    output logic [7:0] lock_loss_count
);

    // The shared counter only ever reaches (longest interval - 1).
    localparam int MAX_AB = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_C  = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int CW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    localparam logic [CW-1:0] PRST_LAST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STAB_LAST = CW'(STABLE_CYCLES - 1);

    localparam logic [1:0] S_PLL_RESET = 2'd0;
    localparam logic [1:0] S_WAIT_LOCK = 2'd1;
    localparam logic [1:0] S_STABLE    = 2'd2;
    localparam logic [1:0] S_RUN       = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sync1_q, lock_s_q;
    logic          lock_timeout_q, lock_timeout_d;

    // Two-flop synchronizer for the asynchronous lock input.
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            sync1_q  <= locked;
            lock_s_q <= sync1_q;
        end
    end

    // Each terminal compare sits in its own branch, so a parameter value of 1
    // leaves the state after one cycle. The counter never wraps or underflows.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q + 1'b1;
        lock_timeout_d = 1'b0;
        case (state_q)
            S_PLL_RESET: begin
                if (cnt_q == PRST_LAST) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            S_WAIT_LOCK: begin
                if (lock_s_q) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == WAIT_LAST) begin
                    state_d        = S_PLL_RESET;
                    cnt_d          = '0;
                    lock_timeout_d = 1'b1;
                end
            end
            S_STABLE: begin
                // Any drop restarts qualification from scratch.
                if (!lock_s_q) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STAB_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            default: begin
                // RUN: the counter is idle. Lock loss and a software request
                // lead to the same place, so one branch covers both.
                cnt_d = '0;
                if (!lock_s_q || sw_reset_req) begin
                    state_d = S_PLL_RESET;
                end
            end
        endcase
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q        <= S_PLL_RESET;
            cnt_q          <= '0;
            lock_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            lock_timeout_q <= lock_timeout_d;
        end
    end

`ifdef PLL_RSTSEQ_LOSS_CNT_EN
    logic       loss_evt;
    logic [7:0] loss_cnt_q;

    // Lock loss takes priority over a coincident software request,
    // so the count advances whenever lock drops in RUN.
    assign loss_evt = (state_q == S_RUN) && !lock_s_q;

    always_ff @(posedge refclk) begin
        if (rst) begin
            loss_cnt_q <= 8'd0;
        end else if (loss_evt && (loss_cnt_q != 8'hFF)) begin
            loss_cnt_q <= loss_cnt_q + 8'd1;
        end
    end

    assign lock_loss_count = loss_cnt_q;
`else
    assign lock_loss_count = 8'd0;
`endif

    assign pll_rst      = (state_q == S_PLL_RESET);
    assign sys_rst      = (state_q != S_RUN);
    assign ready        = (state_q == S_RUN);
    assign lock_timeout = lock_timeout_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pll_reset_sequencer
//
// The whole input waveform (rst, locked, sw_reset_req per edge) is built up
// front. It combines directed scenarios with a randomized tail.
//
// A reference model walks that waveform. It works from the sequencing rules
// using elapsed-time arithmetic and produces the expected outputs after every
// edge.
//
// The driver pushes each edge's expectation as it drives that edge. The
// monitor pops one expectation per edge and compares it with the outputs.
// ----------------------------------------------------------------------------
module tb_pll_reset_sequencer;

    localparam int P = 4;
    localparam int T = 16;
    localparam int S = 8;

`ifdef PLL_RSTSEQ_LOSS_CNT_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    logic       refclk = 1'b1;
    logic       rst = 1'b1;
    logic       locked = 1'b0;
    logic       sw_reset_req = 1'b0;
    logic       pll_rst, sys_rst, ready, lock_timeout;
    logic [7:0] lock_loss_count;

    always #5 refclk = ~refclk;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES(P),
        .LOCK_TIMEOUT  (T),
        .STABLE_CYCLES (S)
    ) dut (
        .refclk         (refclk),
        .rst            (rst),
        .locked         (locked),
        .sw_reset_req   (sw_reset_req),
        .pll_rst        (pll_rst),
        .sys_rst        (sys_rst),
        .ready          (ready),
        .lock_timeout   (lock_timeout),
        .lock_loss_count(lock_loss_count)
    );

    typedef struct packed {
        logic       pll;
        logic       sys;
        logic       rdy;
        logic       to;
        logic [7:0] cnt;
    } obs_t;

    bit   st_rst[$];
    bit   st_lk[$];
    bit   st_sw[$];
    obs_t exp_arr[$];
    obs_t exp_q[$];

    int n_checks   = 0;
    int n_pass     = 0;
    bit stim_done  = 1'b0;
    int sat_mark   = -1;

    task automatic add(input bit r, input bit l, input bit s, input int len);
        for (int k = 0; k < len; k++) begin
            st_rst.push_back(r);
            st_lk.push_back(l);
            st_sw.push_back(s);
        end
    endtask

    // Reference model.
    // entry = edge at which the current phase began.
    // ls    = synchronized lock seen by the decision at this edge.
    task automatic build_model();
        int   ph;
        int   entry;
        int   losses;
        int   age;
        bit   sy;
        bit   ls;
        bit   to;
        obs_t o;
        ph = 0; entry = 0; losses = 0; sy = 1'b0; ls = 1'b0;
        for (int n = 0; n < st_rst.size(); n++) begin
            to = 1'b0;
            if (st_rst[n]) begin
                ph = 0; entry = n; losses = 0; sy = 1'b0; ls = 1'b0;
            end else begin
                age = n - entry;
                case (ph)
                    0: if (age == P) begin ph = 1; entry = n; end
                    1: if (ls) begin ph = 2; entry = n; end
                       else if (age == T) begin ph = 0; entry = n; to = 1'b1; end
                    2: if (!ls) begin ph = 1; entry = n; end
                       else if (age == S) begin ph = 3; entry = n; end
                    default: if (!ls) begin
                                 ph = 0; entry = n;
                                 losses = (losses < 255) ? losses + 1 : 255;
                             end else if (st_sw[n]) begin
                                 ph = 0; entry = n;
                             end
                endcase
                ls = sy;
                sy = st_lk[n];
            end
            o.pll = (ph == 0);
            o.sys = (ph != 3);
            o.rdy = (ph == 3);
            o.to  = to;
            o.cnt = LOSS_EN ? 8'(losses) : 8'd0;
            exp_arr.push_back(o);
        end
    endtask

    // Monitor: one expectation per edge, sampled at the following falling edge.
    initial begin
        obs_t e;
        int   edge_n;
        edge_n = 0;
        forever begin
            @(posedge refclk);
            @(negedge refclk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({pll_rst, sys_rst, ready, lock_timeout, lock_loss_count} === e) begin
                    n_pass++;
                end else begin
                    $display("FAIL outputs edge %0d: got pll_rst=%b sys_rst=%b ready=%b lock_timeout=%b lock_loss_count=%0d, required %b %b %b %b %0d",
                             edge_n, pll_rst, sys_rst, ready, lock_timeout, lock_loss_count,
                             e.pll, e.sys, e.rdy, e.to, e.cnt);
                end
            end else if (!stim_done) begin
                n_checks++;
                $display("FAIL scoreboard edge %0d: got no expectation, required one", edge_n);
            end
            edge_n++;
        end
    end

    // Stimulus and driver.
    initial begin
        bit l;
        int len;

        // Power-up with no lock; covers the periodic timeout.
        add(1, 0, 0, 3);
        add(0, 0, 0, 50);
        // Normal lock, held into RUN.
        add(0, 1, 0, 40);
        // Software request alone.
        add(0, 1, 1, 1);
        add(0, 1, 0, 30);
        // Software request on the same edge that sees lock_s fall.
        add(0, 0, 0, 2);
        add(0, 0, 1, 1);
        add(0, 0, 0, 4);
        add(0, 1, 0, 30);
        // Glitch in STABLE at cnt=5.
        add(1, 1, 0, 1);
        add(0, 1, 0, 9);
        add(0, 0, 0, 1);
        add(0, 1, 0, 30);
        // rst asserted while in STABLE.
        add(1, 1, 0, 1);
        add(0, 1, 0, 8);
        add(1, 1, 0, 1);
        add(0, 1, 0, 30);
        // 300 lock losses from RUN; the counter must saturate.
        for (int i = 0; i < 300; i++) begin
            add(0, 0, 0, 6);
            add(0, 1, 0, 16);
        end
        sat_mark = st_rst.size();
        // Randomized tail.
        for (int s = 0; s < 120; s++) begin
            l   = ($urandom_range(0, 3) != 0);
            len = l ? int'($urandom_range(5, 40)) : int'($urandom_range(1, 8));
            for (int k = 0; k < len; k++) begin
                st_rst.push_back($urandom_range(0, 99) == 0);
                st_lk.push_back(l);
                st_sw.push_back($urandom_range(0, 19) == 0);
            end
        end

        build_model();

        for (int n = 0; n < st_rst.size(); n++) begin
            @(negedge refclk);
            if (n == sat_mark) begin
                n_checks++;
                if (lock_loss_count == (LOSS_EN ? 8'd255 : 8'd0)) begin
                    n_pass++;
                end else begin
                    $display("FAIL saturation: got lock_loss_count=%0d, required %0d",
                             lock_loss_count, LOSS_EN ? 255 : 0);
                end
            end
            rst          = st_rst[n];
            locked       = st_lk[n];
            sw_reset_req = st_sw[n];
            exp_q.push_back(exp_arr[n]);
        end
        stim_done = 1'b1;
        repeat (3) @(negedge refclk);

        n_checks++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
